bch_piso_stream: RTL and testbench
==================================

Name: bch_piso_stream

Overview:
Parametrised parallel-in/serial-out converter for the BCH encoder datapath. It accepts a WIDTH-bit message word through a valid/ready load handshake and emits it one bit per beat on a valid/ready serial stream. The bit order is configurable, and the block flags the last bit of each word. Back-to-back loads are accepted with no idle bubble. It sits between the message source and the serial LFSR encoder, and replaces the fixed 51-bit load/shift register.

Parameters:
WIDTH, 51, message word width in bits; legal range is WIDTH >= 2.
MSB_FIRST, 1, 1 = serialise bit WIDTH-1 first; 0 = serialise bit 0 first.
CNT_W, $clog2(WIDTH), width of the remaining-bit counter; derived, not overridden.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  asynchronous, active-low reset.
flush  input  1  synchronous abort; discards the word in flight.
load_valid  input  1  ps_in holds a word to load.
load_ready  output  1  block can accept a word this cycle.
ps_in  input  WIDTH  parallel message word.
ps_out  output  1  current serial bit.
ps_valid  output  1  ps_out is valid.
ps_ready  input  1  downstream consumes ps_out this cycle.
ps_last  output  1  ps_out is the final bit of the word.
busy  output  1  a word is in flight (state SHIFT).

Behaviour:
- State and storage: FSM states are IDLE and SHIFT. Storage is shreg[WIDTH-1:0] plus cnt[CNT_W-1:0], where cnt is the number of bits remaining after the current one.
- Reset (reset=0, asynchronous):
  - state=IDLE, shreg=0, cnt=0.
  - Outputs: ps_valid=0, ps_last=0, busy=0, ps_out=0, load_ready=1 (once reset is released).
- Definitions:
  - Load accept: load_valid && load_ready.
  - Beat: ps_valid && ps_ready.
- Combinational outputs:
  - load_ready = !flush && (state==IDLE || (beat && cnt==0)).
  - ps_valid = busy = (state==SHIFT).
  - ps_last = (state==SHIFT) && (cnt==0).
  - ps_out = (state==SHIFT) ? (MSB_FIRST ? shreg[WIDTH-1] : shreg[0]) : 0.
- IDLE: on load accept, shreg<=ps_in, cnt<=WIDTH-1, go to SHIFT.
- Latency: the first bit appears on ps_out in the cycle after the accept.
- SHIFT with a beat and cnt!=0:
  - MSB_FIRST=1: shreg shifts toward the MSB.
  - MSB_FIRST=0: shreg shifts toward the LSB.
  - The vacated bit is filled with 0; cnt decrements.
- SHIFT with no beat: shreg, cnt and state hold. ps_out and ps_last stay stable under backpressure.
- SHIFT with a beat and cnt==0 (last bit):
  - If load_valid: new word loaded, cnt<=WIDTH-1, stay in SHIFT (zero-bubble).
  - Otherwise: go to IDLE, shreg<=0.
- flush=1 (any state): next state IDLE, shreg<=0, cnt<=0. Any load offered that cycle is refused (load_ready=0). flush has priority over beats and loads.
- Throughput: exactly WIDTH beats per word. With ps_ready tied to 1 and continuous loads, the stream is gapless.
- Reset asserted mid-word: the word is lost and outputs immediately take their reset values. No partial word is resumed.
- Counter: cnt never wraps. Decrement occurs only when cnt!=0.

Decomposition:
- Shared package bch_pkg holds:
  - BCH_K=51, BCH_N=63, BCH_PARITY=12 (the WIDTH default comes from BCH_K).
  - Enum piso_state_t {IDLE, SHIFT}.
- One natural sub-module: bch_bit_counter, a loadable down-counter with a zero flag, reusable by the encoder's parity-shift phase.
- The shift register and FSM stay in the top level.

Test Plan:
1. WIDTH=8, MSB_FIRST=1, load 8'hA5, ps_ready=1 -> ps_out 1,0,1,0,0,1,0,1 on cycles 1..8 after accept; ps_last=1 only on cycle 8; busy falls on cycle 9.
2. WIDTH=8, MSB_FIRST=0, load 8'hA5 -> ps_out 1,0,1,0,0,1,0,1 reversed to LSB-first order: 1,0,1,0,0,1,0,1 is symmetric, so use 8'h01 -> 1,0,0,0,0,0,0,0.
3. WIDTH=51, back-to-back loads 51'h1 then 51'h4_0000_0000_0000 (bit 50) with ps_ready=1 -> 102 consecutive valid beats. The single 1 appears at beat 51 (last of word 1) and beat 52 (first of word 2). load_ready=1 on beat 51.
4. Backpressure: WIDTH=8, load 8'hF0, hold ps_ready=0 for 5 cycles after beat 2 -> ps_out stays 1 and cnt holds. Remaining bits resume in order, and the total is still 8 beats.
5. flush on beat 3 of 8'hFF with load_valid=1 -> next cycle IDLE, ps_valid=0, ps_out=0. The load is not accepted during the flush cycle and is accepted the cycle after.
6. reset pulsed low mid-word (asynchronous, between clock edges) -> ps_valid, busy, ps_out drop to 0 without a clock edge; after release, the first load behaves as in scenario 1.

Source files
------------

// File: rtl/bch_pkg.sv
// Shared constants and types for the BCH(63,51) encoder datapath.
// Contents:
//   BCH_K, BCH_N, BCH_PARITY : code dimensions (message, codeword, parity bits)
//   piso_state_t             : state type of the parallel-in/serial-out stage
package bch_pkg;

  localparam int BCH_K      = 51;
  localparam int BCH_N      = 63;
  localparam int BCH_PARITY = 12;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } piso_state_t;

endpackage

// File: rtl/bch_piso_stream_if.sv
// Load and serial-stream handshake bundle for bch_piso_stream.
// Signals:
//   load_valid / load_ready / ps_in : parallel word load handshake
//   ps_out / ps_valid / ps_ready    : one-bit-per-beat serial stream
//   ps_last                         : marks the final bit of a word
//   busy                            : a word is in flight
// Modports: slave = the converter, master = source and sink around it.
interface bch_piso_stream_if
  import bch_pkg::*;
#(
  parameter int WIDTH = BCH_K
) ();

  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] ps_in;
  logic             ps_out;
  logic             ps_valid;
  logic             ps_ready;
  logic             ps_last;
  logic             busy;

  modport slave (
    input  load_valid, ps_in, ps_ready,
    output load_ready, ps_out, ps_valid, ps_last, busy
  );

  modport master (
    output load_valid, ps_in, ps_ready,
    input  load_ready, ps_out, ps_valid, ps_last, busy
  );

endinterface

// File: rtl/bch_bit_counter.sv
// Loadable down-counter with a zero flag. Used to track bits remaining in
// the serialiser; also suited to the encoder's parity-shift phase.
// Ports:
//   clk, reset   : clock, asynchronous active-low reset
//   clr_i        : synchronous clear (highest priority)
//   load_i       : load load_val_i
//   load_val_i   : value to load
//   dec_i        : decrement request; ignored at zero so the count never wraps
//   zero_o       : count is zero
module bch_bit_counter #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear, then load, then saturating decrement.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/bch_piso_stream.sv
// Parallel-in/serial-out converter feeding the serial BCH LFSR encoder.
// A WIDTH-bit word is accepted on the load handshake and emitted one bit per
// beat on the serial stream, MSB or LSB first, with ps_last on the final bit.
// A new word can be taken on the last beat of the current one, so continuous
// loads with ps_ready held high give a gapless stream.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   flush : synchronous abort, discards the word in flight and refuses loads
//   s     : load + serial handshake bundle (slave side)
module bch_piso_stream
  import bch_pkg::*;
#(
  parameter int    WIDTH     = BCH_K,
  parameter bit    MSB_FIRST = 1'b1,
  localparam int   CNT_W     = $clog2(WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  bch_piso_stream_if.slave      s
);

  piso_state_t      state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_shift_s;
  logic             shifting_s;
  logic             beat_s;
  logic             accept_s;
  logic             zero_s;

  assign shifting_s = (state_q == SHIFT);
  assign beat_s     = shifting_s && s.ps_ready;
  // Loads are taken when empty, or on the last beat so the next word follows
  // without a bubble.
  assign s.load_ready = !flush && (!shifting_s || (beat_s && zero_s));
  assign accept_s     = s.load_valid && s.load_ready;

  assign s.ps_valid = shifting_s;
  assign s.busy     = shifting_s;
  assign s.ps_last  = shifting_s && zero_s;
  assign s.ps_out   = shifting_s ? (MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0]) : 1'b0;

  // The outgoing end is always the top bit (MSB first) or bottom bit.
  assign shreg_shift_s = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);

  // Remaining-bit counter: bits left after the one currently on ps_out.
  bch_bit_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk        (clk),
    .reset      (reset),
    .clr_i      (flush),
    .load_i     (accept_s),
    .load_val_i (CNT_W'(WIDTH - 1)),
    .dec_i      (beat_s && !zero_s),
    .zero_o     (zero_s)
  );

  // FSM and shift register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
    end else if (flush) begin
      state_q <= IDLE;
      shreg_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_s) begin
            state_q <= SHIFT;
            shreg_q <= s.ps_in;
          end else begin
            state_q <= IDLE;
          end
        end
        SHIFT: begin
          if (beat_s) begin
            if (!zero_s) begin
              shreg_q <= shreg_shift_s;
            end else if (accept_s) begin
              shreg_q <= s.ps_in;
            end else begin
              state_q <= IDLE;
              shreg_q <= '0;
            end
          end else begin
            state_q <= SHIFT;
          end
        end
        default: begin
          state_q <= IDLE;
          shreg_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bch_piso_stream.sv
// Self-checking bench for bch_piso_stream. Three instances: 8-bit MSB first
// (d0), 8-bit LSB first (d1), 51-bit MSB first (d2). Every accepted word is
// expanded into its expected bit sequence and queued; a monitor compares each
// cycle's serial output against the head of that queue.
module tb_bch_piso_stream;

  typedef struct packed {
    logic b;
    logic last;
  } exp_t;

  logic       clk;
  logic       reset;
  logic [2:0] fl_s;

  int checks = 0;
  int errors = 0;

  exp_t q[3][$];
  exp_t pend[3][$];

  logic obs_v, obs_lr, obs_last, obs_out;

  bch_piso_stream_if #(.WIDTH(8))  if_a ();
  bch_piso_stream_if #(.WIDTH(8))  if_b ();
  bch_piso_stream_if #(.WIDTH(51)) if_c ();

  bch_piso_stream #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_a (
    .clk(clk), .reset(reset), .flush(fl_s[0]), .s(if_a));
  bch_piso_stream #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_b (
    .clk(clk), .reset(reset), .flush(fl_s[1]), .s(if_b));
  bch_piso_stream #(.WIDTH(51), .MSB_FIRST(1'b1)) dut_c (
    .clk(clk), .reset(reset), .flush(fl_s[2]), .s(if_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", n, a, e, $time);
    end
  endtask

  // Reference: a word becomes WIDTH bits in serial order, last flag on the final one.
  task automatic push_word(input int d, input int width, input bit msb, input logic [50:0] w);
    exp_t e;
    for (int i = 0; i < width; i++) begin
      e.b    = msb ? w[width-1-i] : w[i];
      e.last = (i == width - 1);
      pend[d].push_back(e);
    end
  endtask

  task automatic clear_model();
    for (int d = 0; d < 3; d++) begin
      q[d].delete();
      pend[d].delete();
    end
  endtask

  task automatic mon(input int d, input logic v, input logic r, input logic o,
                     input logic l, input logic bz, input logic fl);
    exp_t e;
    logic ev;
    ev = (q[d].size() != 0);
    chk($sformatf("d%0d_valid", d), {63'd0, v}, {63'd0, ev});
    chk($sformatf("d%0d_busy", d), {63'd0, bz}, {63'd0, ev});
    if (ev) begin
      e = q[d][0];
      chk($sformatf("d%0d_bit", d), {63'd0, o}, {63'd0, e.b});
      chk($sformatf("d%0d_last", d), {63'd0, l}, {63'd0, e.last});
      if (r) void'(q[d].pop_front());
    end else begin
      chk($sformatf("d%0d_idle_out", d), {63'd0, o}, 64'd0);
      chk($sformatf("d%0d_idle_last", d), {63'd0, l}, 64'd0);
    end
    if (fl) q[d].delete();
    while (pend[d].size() != 0) q[d].push_back(pend[d].pop_front());
  endtask

  // Monitor: samples mid-low-phase, after stimulus settles.
  always @(negedge clk) begin
    #2;
    mon(0, if_a.ps_valid, if_a.ps_ready, if_a.ps_out, if_a.ps_last, if_a.busy, fl_s[0]);
    mon(1, if_b.ps_valid, if_b.ps_ready, if_b.ps_out, if_b.ps_last, if_b.busy, fl_s[1]);
    mon(2, if_c.ps_valid, if_c.ps_ready, if_c.ps_out, if_c.ps_last, if_c.busy, fl_s[2]);
  end

  // One cycle of stimulus on instance d; the others idle with ps_ready high.
  task automatic step(input int d, input bit lv, input logic [50:0] w,
                      input bit rdy, input bit fl);
    @(negedge clk);
    if_a.load_valid = 1'b0; if_a.ps_ready = 1'b1;
    if_b.load_valid = 1'b0; if_b.ps_ready = 1'b1;
    if_c.load_valid = 1'b0; if_c.ps_ready = 1'b1;
    fl_s = 3'b000;
    case (d)
      0: begin if_a.load_valid = lv; if_a.ps_in = w[7:0]; if_a.ps_ready = rdy; end
      1: begin if_b.load_valid = lv; if_b.ps_in = w[7:0]; if_b.ps_ready = rdy; end
      default: begin if_c.load_valid = lv; if_c.ps_in = w; if_c.ps_ready = rdy; end
    endcase
    fl_s[d] = fl;
    #1;
    if (if_a.load_valid && if_a.load_ready) push_word(0, 8, 1'b1, {43'd0, if_a.ps_in});
    if (if_b.load_valid && if_b.load_ready) push_word(1, 8, 1'b0, {43'd0, if_b.ps_in});
    if (if_c.load_valid && if_c.load_ready) push_word(2, 51, 1'b1, if_c.ps_in);
    case (d)
      0: begin obs_v = if_a.ps_valid; obs_lr = if_a.load_ready; obs_last = if_a.ps_last; obs_out = if_a.ps_out; end
      1: begin obs_v = if_b.ps_valid; obs_lr = if_b.load_ready; obs_last = if_b.ps_last; obs_out = if_b.ps_out; end
      default: begin obs_v = if_c.ps_valid; obs_lr = if_c.load_ready; obs_last = if_c.ps_last; obs_out = if_c.ps_out; end
    endcase
  endtask

  task automatic drain(input int n);
    repeat (n) step(0, 1'b0, 51'd0, 1'b1, 1'b0);
  endtask

  task automatic run_s1(input string tag);
    logic [7:0] pat;
    pat = 8'hA5;
    step(0, 1'b1, 51'hA5, 1'b1, 1'b0);
    chk({tag, "_accept"}, {63'd0, obs_lr}, 64'd1);
    for (int k = 1; k <= 8; k++) begin
      step(0, 1'b0, 51'd0, 1'b1, 1'b0);
      chk({tag, "_valid"}, {63'd0, obs_v}, 64'd1);
      chk({tag, "_bit"}, {63'd0, obs_out}, {63'd0, pat[8-k]});
      chk({tag, "_last"}, {63'd0, obs_last}, (k == 8) ? 64'd1 : 64'd0);
    end
    step(0, 1'b0, 51'd0, 1'b1, 1'b0);
    chk({tag, "_busy_fall"}, {63'd0, obs_v}, 64'd0);
  endtask

  initial begin
    int beats;
    logic [63:0] rw;
    reset = 1'b0;
    fl_s  = 3'b000;
    if_a.load_valid = 1'b0; if_a.ps_in = 8'd0;  if_a.ps_ready = 1'b1;
    if_b.load_valid = 1'b0; if_b.ps_in = 8'd0;  if_b.ps_ready = 1'b1;
    if_c.load_valid = 1'b0; if_c.ps_in = 51'd0; if_c.ps_ready = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("rst_load_ready_a", {63'd0, if_a.load_ready}, 64'd1);
    chk("rst_load_ready_c", {63'd0, if_c.load_ready}, 64'd1);
    chk("rst_out_a", {63'd0, if_a.ps_out}, 64'd0);

    // Scenario 1: 8'hA5 MSB first.
    run_s1("s1");

    // Scenario 2: 8'h01 LSB first -> 1 then seven 0s.
    step(1, 1'b1, 51'h01, 1'b1, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      step(1, 1'b0, 51'd0, 1'b1, 1'b0);
      chk("s2_bit", {63'd0, obs_out}, (k == 1) ? 64'd1 : 64'd0);
      chk("s2_last", {63'd0, obs_last}, (k == 8) ? 64'd1 : 64'd0);
    end
    step(1, 1'b0, 51'd0, 1'b1, 1'b0);
    chk("s2_idle", {63'd0, obs_v}, 64'd0);

    // Scenario 3: WIDTH=51 back-to-back, bit 0 then bit 50.
    step(2, 1'b1, 51'h1, 1'b1, 1'b0);
    for (int k = 1; k <= 102; k++) begin
      step(2, (k == 51), 51'h4_0000_0000_0000, 1'b1, 1'b0);
      chk("s3_valid", {63'd0, obs_v}, 64'd1);
      chk("s3_bit", {63'd0, obs_out}, ((k == 51) || (k == 52)) ? 64'd1 : 64'd0);
      if (k == 51) chk("s3_ready_last", {63'd0, obs_lr}, 64'd1);
    end
    step(2, 1'b0, 51'd0, 1'b1, 1'b0);
    chk("s3_idle", {63'd0, obs_v}, 64'd0);

    // Scenario 4: backpressure on 8'hF0 after two beats.
    beats = 0;
    step(0, 1'b1, 51'hF0, 1'b1, 1'b0);
    for (int k = 0; k < 2; k++) begin
      step(0, 1'b0, 51'd0, 1'b1, 1'b0);
      if (obs_v) beats++;
    end
    for (int k = 0; k < 5; k++) begin
      step(0, 1'b0, 51'd0, 1'b0, 1'b0);
      chk("s4_hold_bit", {63'd0, obs_out}, 64'd1);
      chk("s4_hold_valid", {63'd0, obs_v}, 64'd1);
      chk("s4_hold_last", {63'd0, obs_last}, 64'd0);
    end
    for (int k = 0; k < 20; k++) begin
      step(0, 1'b0, 51'd0, 1'b1, 1'b0);
      if (obs_v) beats++;
    end
    chk("s4_beats", beats, 64'd8);

    // Scenario 5: flush on beat 3 of 8'hFF with a load offered.
    step(0, 1'b1, 51'hFF, 1'b1, 1'b0);
    step(0, 1'b0, 51'd0, 1'b1, 1'b0);
    step(0, 1'b0, 51'd0, 1'b1, 1'b0);
    step(0, 1'b1, 51'h3C, 1'b1, 1'b1);
    chk("s5_refused", {63'd0, obs_lr}, 64'd0);
    step(0, 1'b1, 51'h3C, 1'b1, 1'b0);
    chk("s5_flushed_valid", {63'd0, obs_v}, 64'd0);
    chk("s5_flushed_out", {63'd0, obs_out}, 64'd0);
    chk("s5_accept_after", {63'd0, obs_lr}, 64'd1);
    drain(12);

    // Scenario 6: asynchronous reset mid-word.
    step(0, 1'b1, 51'hA5, 1'b1, 1'b0);
    step(0, 1'b0, 51'd0, 1'b1, 1'b0);
    step(0, 1'b0, 51'd0, 1'b1, 1'b0);
    @(posedge clk);
    #3;
    chk("s6_pre_valid", {63'd0, if_a.ps_valid}, 64'd1);
    reset = 1'b0;
    #1;
    chk("s6_valid", {63'd0, if_a.ps_valid}, 64'd0);
    chk("s6_busy", {63'd0, if_a.busy}, 64'd0);
    chk("s6_out", {63'd0, if_a.ps_out}, 64'd0);
    clear_model();
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("s6_load_ready", {63'd0, if_a.load_ready}, 64'd1);
    run_s1("s6");

    // Randomised traffic on each instance.
    for (int d = 0; d < 3; d++) begin
      repeat (400) begin
        rw = {$urandom(), $urandom()};
        step(d, ($urandom_range(0, 1) == 0), rw[50:0],
             ($urandom_range(0, 3) != 0), ($urandom_range(0, 39) == 0));
      end
      drain(60);
    end
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("d%0d_end_empty", d), q[d].size(), 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
